// File: rtl/drop_pkg.sv
// Shared types and constants for the baggage-drop timing front-end.
package drop_pkg;

   localparam int SENSOR_W   = 8;
   localparam int T_W        = 16;
   localparam int ROOT_STEPS = 12;
   localparam int RAD_W      = 24;
   localparam int FRAC_BITS  = 8;

   typedef enum logic [1:0] {
      IDLE,
      AVG,
      ROOT,
      DONE
   } state_t;

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one result bit per step, MSB first.
module isqrt_seq #(
   parameter int RAD_W = 24,
   parameter int STEPS = RAD_W / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [RAD_W-1:0] rad_in,
   input  logic             step,
   output logic             done,
   output logic [STEPS-1:0] root
);

   localparam int REM_W = STEPS + 2;
   localparam int CNT_W = $clog2(STEPS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
   localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(STEPS);

   logic [RAD_W-1:0] rad_q;
   logic [REM_W-1:0] rem_q;
   logic [STEPS-1:0] root_q;
   logic [CNT_W-1:0] cnt_q;

   logic [REM_W-1:0] rem_sh;
   logic [REM_W-1:0] trial;
   logic             fits;

   // The remainder never exceeds 2*root, so its top two bits are always zero before the shift.
   always_comb begin
      rem_sh = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
      trial  = {root_q, 2'b01};
      fits   = (rem_sh >= trial);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         rad_q  <= rad_in;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
      end else if (step && (cnt_q != END_CNT)) begin
         rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
         rem_q  <= fits ? (rem_sh - trial) : rem_sh;
         root_q <= {root_q[STEPS-2:0], fits};
         cnt_q  <= cnt_q + CNT_W'(1);
      end
   end

   // High during the step that produces the final result bit.
   assign done = step && (cnt_q == LAST_CNT);
   assign root = root_q;

endmodule

// File: rtl/drop_timing_unit.sv
// Captures sensor heights and limit, averages the healthy sensors and returns sqrt(height) in Q8.8.
module drop_timing_unit #(
   parameter int SENSOR_W   = drop_pkg::SENSOR_W,
   parameter int T_W        = drop_pkg::T_W,
   parameter int ROOT_STEPS = drop_pkg::ROOT_STEPS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [SENSOR_W-1:0] sensor1,
   input  logic [SENSOR_W-1:0] sensor2,
   input  logic [SENSOR_W-1:0] sensor3,
   input  logic [SENSOR_W-1:0] sensor4,
   input  logic [T_W-1:0]      t_lim_in,
   input  logic                drop_en_in,
   output logic [T_W-1:0]      t_act,
   output logic [T_W-1:0]      t_lim,
   output logic                drop_en,
   output logic                busy,
   output logic                valid
);

   import drop_pkg::*;

   localparam int RAD_W = SENSOR_W + 2 * FRAC_BITS;

   state_t state_q, state_d;

   logic [SENSOR_W-1:0]   s1_q, s2_q, s3_q, s4_q;
   logic [T_W-1:0]        t_lim_q;
   logic                  drop_q;
   logic                  sq_load, sq_step, sq_done;
   logic [ROOT_STEPS-1:0] sq_root;
   logic [SENSOR_W-1:0]   height;

   // A zero reading marks a faulty sensor; a pair is usable only when both readings are nonzero.
   function automatic logic [SENSOR_W-1:0] avg_height(
      input logic [SENSOR_W-1:0] a, b, c, d
   );
      logic [SENSOR_W+1:0] sum4;
      logic [SENSOR_W:0]   sum2;
      logic                ok13, ok24;
      ok13 = (a != '0) && (c != '0);
      ok24 = (b != '0) && (d != '0);
      sum4 = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + (SENSOR_W+2)'(2);
      if (ok13 && ok24) begin
         return sum4[SENSOR_W+1:2];
      end else if (ok24) begin
         sum2 = {1'b0, b} + {1'b0, d} + (SENSOR_W+1)'(1);
         return sum2[SENSOR_W:1];
      end else if (ok13) begin
         sum2 = {1'b0, a} + {1'b0, c} + (SENSOR_W+1)'(1);
         return sum2[SENSOR_W:1];
      end
      return '0;
   endfunction

   assign height = avg_height(s1_q, s2_q, s3_q, s4_q);

   isqrt_seq #(
      .RAD_W (RAD_W),
      .STEPS (ROOT_STEPS)
   ) u_isqrt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (sq_load),
      .rad_in ({height, {(2*FRAC_BITS){1'b0}}}),
      .step   (sq_step),
      .done   (sq_done),
      .root   (sq_root)
   );

   always_comb begin
      state_d = state_q;
      sq_load = 1'b0;
      sq_step = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = AVG;
         AVG: begin
            sq_load = 1'b1;
            state_d = ROOT;
         end
         ROOT: begin
            sq_step = 1'b1;
            if (sq_done) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         s4_q    <= '0;
         t_lim_q <= '0;
         drop_q  <= 1'b0;
         t_act   <= '0;
         t_lim   <= '0;
         drop_en <= 1'b0;
         valid   <= 1'b0;
      end else begin
         state_q <= state_d;
         valid   <= 1'b0;
         if ((state_q == IDLE) && start) begin
            s1_q    <= sensor1;
            s2_q    <= sensor2;
            s3_q    <= sensor3;
            s4_q    <= sensor4;
            t_lim_q <= t_lim_in;
            drop_q  <= drop_en_in;
         end
         // Outputs move together only here, so downstream never sees a partial update.
         if (state_q == DONE) begin
            t_act   <= {{(T_W-ROOT_STEPS){1'b0}}, sq_root};
            t_lim   <= t_lim_q;
            drop_en <= drop_q;
            valid   <= 1'b1;
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: doc/drop_timing_unit.md
Name: drop_timing_unit

Overview:
- Sequential front-end of the baggage-drop path. Sits directly upstream of the display/drop decision stage and produces its `t_act`, `t_lim` and `drop_en` inputs.
- Captures four height-sensor readings plus the limit time and drop request, then computes a fault-tolerant average height.
- Derives `t_act` as a Q8.8 fixed-point square root using a multi-cycle iterative root.
- Holds all results stable until the next request.

Parameters:
- SENSOR_W, 8, width of each sensor reading (unsigned height).
- T_W, 16, width of `t_act`/`t_lim` (Q8.8).
- ROOT_STEPS, 12, iterations of the digit-by-digit root; must equal (SENSOR_W+16)/2.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to capture inputs and compute.
- sensor1  input  8  height sensor 1; 0 = faulty.
- sensor2  input  8  height sensor 2; 0 = faulty.
- sensor3  input  8  height sensor 3; 0 = faulty.
- sensor4  input  8  height sensor 4; 0 = faulty.
- t_lim_in  input  16  limit time, Q8.8, same scale as `t_act`.
- drop_en_in  input  1  drop request from operator.
- t_act  output  16  computed time, Q8.8, registered.
- t_lim  output  16  captured limit, registered.
- drop_en  output  1  captured drop request, registered.
- busy  output  1  high from the cycle after accepted start until valid.
- valid  output  1  one-cycle pulse when new outputs take effect.

Interface decision: one clock (`clk`); reset `rst_n` is synchronous and active-low.

Behaviour:
- Reset (`rst_n`=0 at clk edge):
  - State goes to IDLE.
  - `t_act`=0, `t_lim`=0, `drop_en`=0, `busy`=0, `valid`=0; internal registers cleared.
  - Consequence: downstream shows the "Cold" state after reset.
- FSM states: IDLE, AVG, ROOT, DONE.
- IDLE:
  - On `start`=1, capture sensor1..4, `t_lim_in` and `drop_en_in` into shadow registers, then go to AVG.
  - Outputs keep their previous values.
- AVG, one cycle; compute height H (8-bit):
  - s1==0 or s3==0, and s2,s4 both nonzero: H = (s2+s4+1)>>1.
  - s2==0 or s4==0, and s1,s3 both nonzero: H = (s1+s3+1)>>1.
  - All nonzero: H = (s1+s2+s3+s4+2)>>2, using a 10-bit sum.
  - Both pairs contain a zero: H = 0.
  - Load radicand R = H<<16 (24-bit); go to ROOT.
- ROOT, exactly ROOT_STEPS cycles:
  - Restoring digit-by-digit integer square root, one result bit per cycle, MSB first.
  - Result = floor(sqrt(R)), 12 bits, zero-extended to 16. This is sqrt(H) in Q8.8.
- DONE, one cycle:
  - `t_act`, `t_lim`, `drop_en` update from the root result and shadow registers; `valid`=1.
  - Return to IDLE.
- Latency: start sampled at edge N → `valid` high in cycle N+14; outputs valid from the same edge.
- `busy` is high during AVG, ROOT and DONE; low in IDLE.
- `start` while busy is ignored, not queued. `start` in the DONE cycle is also ignored.
- Inputs changing after capture have no effect on the running computation.
- Outputs change only at DONE, so the downstream combinational decoder never sees partial results.
- Reset mid-computation aborts immediately: outputs go to 0 and no `valid` is issued.
- H=0 gives `t_act`=0. Maximum H=255 gives 0x0FF7, so no overflow is possible.

Decomposition:
- Shared package `drop_pkg`:
  - FSM state enum {IDLE, AVG, ROOT, DONE}.
  - Constants SENSOR_W, T_W, ROOT_STEPS and radicand width 24.
  - Q8.8 fraction-bits constant (8).
- One sub-module `isqrt_seq`:
  - Generic sequential integer root with load/step/done.
  - Parameterised radicand width; owns the remainder/result/iteration counter.
- The parent owns capture, averaging and output registers.

Test Plan:
- Reset with `rst_n`=0 for 2 cycles → all outputs 0, `busy`=0, `valid`=0.
- Sensors 100,100,100,100, `t_lim_in`=0x0C00, `drop_en_in`=1, start → `valid` at N+14, `t_act`=0x0A00, `t_lim`=0x0C00, `drop_en`=1.
- Sensors 0,50,100,51, start → H=51, `t_act`=0x0724.
- Sensors all 255 → `t_act`=0x0FF7. Then sensors 2,2,2,2 → `t_act`=0x016A. Then 0,0,7,7 → `t_act`=0.
- Start at N, second start at N+5 with different sensors → single `valid` at N+14 carrying the first request's results only; outputs unchanged through N+13.
- Start, then `rst_n`=0 at N+7 → outputs 0 from the next edge, no `valid` pulse. Start after reset → normal completion 14 cycles later.
